// File: rtl/posit_pkg.sv
// posit_pkg: shared definitions for the posit packer arbiter.
//   NBITS_DEFAULT / ES_DEFAULT : default posit word and exponent field widths
//   state_t                    : grant FSM state encoding
//   tag_width()                : width of a requester index for n requesters
package posit_pkg;

  localparam int NBITS_DEFAULT = 16;
  localparam int ES_DEFAULT    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PACK = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/packer.sv
// packer: combinational posit encoder (positive values only).
//   seed  : signed regime value k
//   exp   : ES-bit exponent field
//   frac  : fraction bits after the hidden one, MSB-aligned
//   posit : NBITS posit word, sign bit 0
// The regime is clamped to [-(NBITS-2), NBITS-2], so the result stays between
// minpos and maxpos. Dropped bits are rounded to nearest, ties to even.
module packer #(
  parameter int NBITS = 16,
  parameter int ES    = 3
) (
  input  logic [NBITS-1:0] seed,
  input  logic [ES-1:0]    exp,
  input  logic [NBITS-1:0] frac,
  output logic [NBITS-1:0] posit
);

  localparam int BW = NBITS - 1;           // body bits after the sign
  localparam int EW = 1 + ES + NBITS + BW; // terminator, exp, frac, headroom
  localparam logic signed [NBITS-1:0] KMAX = NBITS'(NBITS - 2);
  localparam logic signed [NBITS-1:0] KMIN = NBITS'(2 - NBITS);
  localparam logic [NBITS-1:0]        ONE  = NBITS'(1);

  logic signed [NBITS-1:0] k;
  logic                    neg;
  logic [NBITS-1:0]        run;
  logic [EW-1:0]           fill;
  logic [EW-1:0]           shifted;
  logic [BW-1:0]           body;
  logic                    guard;
  logic                    sticky;

  always_comb begin
    k = $signed(seed);
    if ($signed(seed) > KMAX) begin
      k = KMAX;
    end else if ($signed(seed) < KMIN) begin
      k = KMIN;
    end
    neg = k[NBITS-1];
    // Regime run length: k+1 ones for k >= 0, -k zeros for k < 0; the bit
    // after the run is the opposite value (the terminator, equal to neg).
    run     = neg ? $unsigned(-k) : ($unsigned(k) + ONE);
    fill    = neg ? '0 : ~({EW{1'b1}} >> run);
    shifted = ({neg, exp, frac, {BW{1'b0}}} >> run) | fill;
    body    = shifted[EW-1 -: BW];
    guard   = shifted[EW-1-BW];
    sticky  = |shifted[EW-2-BW:0];
    // With the clamp, a saturated regime always has guard = 0, so the
    // increment cannot carry into the sign bit.
    posit   = {1'b0, body + BW'(guard & (sticky | body[0]))};
  end

endmodule

// File: rtl/posit_req_arbiter.sv
// posit_req_arbiter: combinational grant selection.
//   req_valid : per-requester request
//   ptr       : round-robin start index (only with POSIT_ARB_RR_EN)
//   gnt       : one-hot grant (zero when nothing requests)
//   gnt_idx   : encoded index of the granted requester
//   gnt_any   : some requester is granted
// POSIT_ARB_RR_EN defined: search starts at ptr and wraps; otherwise the
// lowest index wins.
module posit_req_arbiter
  import posit_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int TW   = tag_width(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
`ifdef POSIT_ARB_RR_EN
  input  logic [TW-1:0]   ptr,
`endif
  output logic [NREQ-1:0] gnt,
  output logic [TW-1:0]   gnt_idx,
  output logic            gnt_any
);

`ifdef POSIT_ARB_RR_EN
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = TW'(idx);
        gnt_any  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_any && req_valid[i]) begin
        gnt[i]  = 1'b1;
        gnt_idx = TW'(i);
        gnt_any = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/posit_packer_arbiter.sv
// posit_packer_arbiter: shares one packer between NREQ valid/ready requesters.
//   clk, rst                   : clock, async active-high reset
//   req_valid / req_ready      : per-requester handshake (ready is one-hot or 0)
//   req_seed/req_exp/req_frac  : packed per-requester operands
//   out_valid / out_ready      : result handshake
//   out_posit / out_tag        : packed posit and owning requester index
// Macro POSIT_ARB_RR_EN selects round-robin arbitration (default: fixed
// priority, lowest index first).
//
// state | meaning
// IDLE  | waiting for a request; winner's operands captured on the edge
// LOAD  | operand registers drive the packer
// PACK  | packer result captured into out_posit
// DONE  | out_valid high until out_ready
module posit_packer_arbiter
  import posit_pkg::*;
#(
  parameter  int NBITS = NBITS_DEFAULT,
  parameter  int ES    = ES_DEFAULT,
  parameter  int NREQ  = 2,
  localparam int TW    = tag_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*NBITS-1:0] req_seed,
  input  logic [NREQ*ES-1:0]    req_exp,
  input  logic [NREQ*NBITS-1:0] req_frac,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [NBITS-1:0]      out_posit,
  output logic [TW-1:0]         out_tag
);

  state_t           state_q, state_d;
  logic [NBITS-1:0] seed_q, seed_d;
  logic [ES-1:0]    exp_q, exp_d;
  logic [NBITS-1:0] frac_q, frac_d;
  logic [TW-1:0]    tag_q, tag_d;
  logic [NBITS-1:0] out_posit_q, out_posit_d;
  logic [TW-1:0]    out_tag_q, out_tag_d;
  logic             out_valid_q, out_valid_d;

  logic [NREQ-1:0]  gnt;
  logic [TW-1:0]    gnt_idx;
  logic             gnt_any;
  logic [NBITS-1:0] pack_res;

`ifdef POSIT_ARB_RR_EN
  logic [TW-1:0]    ptr_q, ptr_d;
`endif

  posit_req_arbiter #(.NREQ(NREQ)) u_arb (
    .req_valid (req_valid),
`ifdef POSIT_ARB_RR_EN
    .ptr       (ptr_q),
`endif
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_any   (gnt_any)
  );

  packer #(.NBITS(NBITS), .ES(ES)) u_packer (
    .seed  (seed_q),
    .exp   (exp_q),
    .frac  (frac_q),
    .posit (pack_res)
  );

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    exp_d       = exp_q;
    frac_d      = frac_q;
    tag_d       = tag_q;
    out_posit_d = out_posit_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;
`ifdef POSIT_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          seed_d  = req_seed[gnt_idx*NBITS +: NBITS];
          exp_d   = req_exp[gnt_idx*ES +: ES];
          frac_d  = req_frac[gnt_idx*NBITS +: NBITS];
          tag_d   = gnt_idx;
          state_d = LOAD;
`ifdef POSIT_ARB_RR_EN
          ptr_d   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + TW'(1);
`endif
        end
      end
      LOAD: state_d = PACK;
      PACK: begin
        out_posit_d = pack_res;
        out_tag_d   = tag_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      seed_q      <= '0;
      exp_q       <= '0;
      frac_q      <= '0;
      tag_q       <= '0;
      out_posit_q <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
`ifdef POSIT_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      exp_q       <= exp_d;
      frac_q      <= frac_d;
      tag_q       <= tag_d;
      out_posit_q <= out_posit_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
`ifdef POSIT_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  // Ready is gated by rst so nothing is accepted while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst) begin
      req_ready = gnt;
    end
  end

  assign out_valid = out_valid_q;
  assign out_posit = out_posit_q;
  assign out_tag   = out_tag_q;

endmodule
